intc_vec_ctrl: RTL and testbench

- Parametrised interrupt controller; successor to the fixed three-key controller.
- Accepts NUM_SRC asynchronous sources. Each source is configured as falling-edge (active-low keys) or level-high (SD done, timer).
- Latches events into pending bits, masks them per source, and selects the highest-priority pending source.
- Runs an IDLE/ENTRY/ACTIVE handshake with the core trap logic; sits between board I/O plus peripherals and the RISC-V core CSR/trap unit.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_src_cond.sv | 78 +++++++
 rtl/intc_vec_ctrl.sv | 114 +++++++++++
 tb/tb_intc_vec_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
//   intc_state_e    : trap handshake state (IDLE / ENTRY / ACTIVE)
//   INTC_DEB_CYCLES : default debounce stable-count
//   DEB_CNT_W       : width of the per-source debounce counter
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    ACTIVE = 2'd2
  } intc_state_e;

  localparam int unsigned INTC_DEB_CYCLES = 16;
  localparam int unsigned DEB_CNT_W       = $clog2(INTC_DEB_CYCLES + 1);

endpackage

// File: rtl/intc_src_cond.sv
// Per-source conditioning: synchroniser, optional debounce filter and
// event detection (falling edge or level-high).
// Optional feature macro: INTC_DEBOUNCE_EN (debounce on edge-mode sources).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   src        : raw source, asynchronous to clk
//   evt_c      : combinational event flag for the pending logic
module intc_src_cond
  import intc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          IS_EDGE     = 1'b1
`ifdef INTC_DEBOUNCE_EN
  , parameter int unsigned DEB_CYCLES = INTC_DEB_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic evt_c
);

  // Edge sources idle high (active-low keys), level sources idle low.
  localparam logic RST_VAL = IS_EDGE;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cond;

  // Metastability synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], src};
  end

`ifdef INTC_DEBOUNCE_EN
  if (IS_EDGE) begin : g_deb
    logic [DEB_CNT_W-1:0] cnt_q;
    logic                 filt_q;

    // Filtered level follows the synchroniser only after DEB_CYCLES
    // consecutive samples that differ from the current filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        filt_q <= 1'b1;
      end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_CNT_W'(DEB_CYCLES - 1)) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + DEB_CNT_W'(1);
      end
    end

    assign cond = filt_q;
  end else begin : g_nodeb
    assign cond = sync_q[SYNC_STAGES-1];
  end
`else
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  if (IS_EDGE) begin : g_edge
    logic hist_q;

    // History flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist_q <= RST_VAL;
      else        hist_q <= cond;
    end

    assign evt_c = hist_q & ~cond;
  end else begin : g_level
    assign evt_c = cond;
  end

endmodule

// File: rtl/intc_vec_ctrl.sv
// Parametrised vectored interrupt controller: conditions NUM_SRC async
// sources, latches pending bits, picks the highest-numbered enabled
// pending source and runs the IDLE/ENTRY/ACTIVE handshake with the core.
// Optional feature macro: INTC_DEBOUNCE_EN (debounce on edge-mode sources).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   src_i           : raw interrupt sources
//   irq_en_i        : per-source enable mask
//   int_mstatus_mie : global interrupt enable
//   mret_en         : core executing mret
//   trap_entry_en   : one-cycle take-trap pulse
//   trap_exit_en    : trap exit strobe (follows mret_en)
//   int_index       : claimed source id, stable while active
//   active_o        : handler in progress
//   pending_o       : raw pending bits
module intc_vec_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned         NUM_SRC     = 8,
  parameter int unsigned         IDX_W       = 4,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0]  EDGE_MASK   = NUM_SRC'(8'h0F),
  parameter int unsigned         DEB_CYCLES  = INTC_DEB_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] irq_en_i,
  input  logic               int_mstatus_mie,
  input  logic               mret_en,
  output logic               trap_entry_en,
  output logic               trap_exit_en,
  output logic [IDX_W-1:0]   int_index,
  output logic               active_o,
  output logic [NUM_SRC-1:0] pending_o
);

  // Elaboration-time parameter sanity check.
  if ((NUM_SRC < 2) || (NUM_SRC > 16) || ((2 ** IDX_W) < NUM_SRC) ||
      (SYNC_STAGES < 2) || (DEB_CYCLES == 0) ||
      (DEB_CYCLES >= (2 ** DEB_CNT_W))) begin : g_param_check
    $error("intc_vec_ctrl: illegal parameter combination");
  end

  intc_state_e        state_q;
  logic [NUM_SRC-1:0] evt_c;
  logic [NUM_SRC-1:0] req_c;
  logic [NUM_SRC-1:0] clr_c;
  logic [IDX_W-1:0]   win_c;
  logic               claim_c;

  // One conditioning channel per source.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intc_src_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .IS_EDGE     (EDGE_MASK[g])
`ifdef INTC_DEBOUNCE_EN
      , .DEB_CYCLES (DEB_CYCLES)
`endif
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .src   (src_i[g]),
      .evt_c (evt_c[g])
    );
  end

  assign req_c = pending_o & irq_en_i;

  // Fixed priority: ascending scan so the highest source number wins.
  always_comb begin
    win_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_c[i]) win_c = IDX_W'(i);
    end
  end

  assign claim_c = (|req_c) && int_mstatus_mie && (state_q == IDLE);
  assign clr_c   = claim_c ? (NUM_SRC'(1) << win_c) : '0;

  // Pending bits: a new event in the claim cycle keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_o <= '0;
    else        pending_o <= (pending_o & ~clr_c) | evt_c;
  end

  // Trap handshake FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      trap_entry_en <= 1'b0;
      int_index     <= '0;
      active_o      <= 1'b0;
    end else begin
      trap_entry_en <= 1'b0;
      active_o      <= (state_q == ACTIVE);
      case (state_q)
        IDLE: begin
          if (claim_c) begin
            int_index     <= win_c;
            trap_entry_en <= 1'b1;
            state_q       <= ENTRY;
          end
        end
        ENTRY:   state_q <= ACTIVE;
        ACTIVE:  if (mret_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trap_exit_en = mret_en;

endmodule

// File: tb/tb_intc_vec_ctrl.sv
// Self-checking bench for intc_vec_ctrl: scenario tasks with inline checks
// plus a scoreboard of expected claim ids popped on every trap_entry_en.
module tb_intc_vec_ctrl;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SYNC    = 2;
`ifdef INTC_DEBOUNCE_EN
  localparam int unsigned DEB_LAT = 16;
`else
  localparam int unsigned DEB_LAT = 0;
`endif
  localparam int unsigned EDGE_LAT = SYNC + DEB_LAT;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] irq_en;
  logic               mie;
  logic               mret;
  logic               trap_entry_en;
  logic               trap_exit_en;
  logic [IDX_W-1:0]   int_index;
  logic               active_o;
  logic [NUM_SRC-1:0] pending_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDX_W-1:0] exp_q[$];

  intc_vec_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .IDX_W       (IDX_W),
    .SYNC_STAGES (SYNC),
    .EDGE_MASK   (8'h0F),
    .DEB_CYCLES  (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_i           (src),
    .irq_en_i        (irq_en),
    .int_mstatus_mie (mie),
    .mret_en         (mret),
    .trap_entry_en   (trap_entry_en),
    .trap_exit_en    (trap_exit_en),
    .int_index       (int_index),
    .active_o        (active_o),
    .pending_o       (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every trap pulse must match the next expected claim id.
  always @(negedge clk) begin
    if (rst_n && trap_entry_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_claim: got int_index=%0d, expected no claim", int_index);
      end else begin
        logic [IDX_W-1:0] e;
        e = exp_q.pop_front();
        if (int_index !== e) begin
          n_fail++;
          $display("FAIL sb_claim: got int_index=%0d, expected %0d", int_index, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trap(input string name);
    int n = 0;
    while (trap_entry_en !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    n_tests++;
    if (trap_entry_en !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: trap_entry_en never rose within 60 cycles", name);
    end
  endtask

  task automatic do_mret();
    int n = 0;
    while (active_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_tests++;
    if (active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_wait: active_o=%b, expected 1 within 20 cycles", active_o);
    end
    mret = 1'b1;
    step();
    mret = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    src    = 8'h0F;
    irq_en = 8'hFF;
    mie    = 1'b1;
    mret   = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({pending_o, trap_entry_en, int_index, active_o, trap_exit_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: pend=%h te=%b idx=%0d act=%b tx=%b, expected all 0",
               pending_o, trap_entry_en, int_index, active_o, trap_exit_en);
    end
    rst_n = 1'b1;
    repeat (4) step();
    n_tests++;
    if (pending_o !== '0 || trap_entry_en !== 1'b0 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: pend=%h te=%b act=%b, expected 0/0/0",
               pending_o, trap_entry_en, active_o);
    end
  endtask

  task automatic test_edge_latency();
    src[2] = 1'b0;
    exp_q.push_back(IDX_W'(2));
    for (int k = 0; k <= int'(EDGE_LAT) + 3; k++) begin
      step();
      if (k == int'(EDGE_LAT) - 1) begin
        n_tests++;
        if (pending_o[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_pend_early: pending[2]=%b at edge %0d, expected 0", pending_o[2], k);
        end
      end
      if (k == int'(EDGE_LAT)) begin
        n_tests++;
        if (pending_o[2] !== 1'b1 || trap_entry_en !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_pend: pending[2]=%b te=%b at edge %0d, expected 1/0",
                   pending_o[2], trap_entry_en, k);
        end
      end
      if (k == int'(EDGE_LAT) + 1) begin
        n_tests++;
        if (trap_entry_en !== 1'b1 || int_index !== IDX_W'(2) || pending_o[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_trap: te=%b idx=%0d pend[2]=%b at edge %0d, expected 1/2/0",
                   trap_entry_en, int_index, pending_o[2], k);
        end
      end
      if (k == int'(EDGE_LAT) + 2) begin
        n_tests++;
        if (trap_entry_en !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_pulse: te=%b at edge %0d, expected 0", trap_entry_en, k);
        end
      end
      if (k == int'(EDGE_LAT) + 3) begin
        n_tests++;
        if (active_o !== 1'b1 || int_index !== IDX_W'(2)) begin
          n_fail++;
          $display("FAIL lat_active: act=%b idx=%0d at edge %0d, expected 1/2",
                   active_o, int_index, k);
        end
      end
    end
    src[2] = 1'b1;
    mret = 1'b1;
    #1;
    n_tests++;
    if (trap_exit_en !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_exit: trap_exit_en=%b, expected 1", trap_exit_en);
    end
    step();
    mret = 1'b0;
    repeat (2) step();
    n_tests++;
    if (active_o !== 1'b0 || trap_exit_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_idle: act=%b tx=%b, expected 0/0", active_o, trap_exit_en);
    end
  endtask

  task automatic test_priority();
    src[1] = 1'b0;
    src[6] = 1'b1;
    exp_q.push_back(IDX_W'(6));
    exp_q.push_back(IDX_W'(1));
    step();
    src[6] = 1'b0;
    wait_trap("prio_first");
    n_tests++;
    if (int_index !== IDX_W'(6)) begin
      n_fail++;
      $display("FAIL prio_first: int_index=%0d, expected 6", int_index);
    end
    do_mret();
    wait_trap("prio_second");
    n_tests++;
    if (int_index !== IDX_W'(1)) begin
      n_fail++;
      $display("FAIL prio_second: int_index=%0d, expected 1", int_index);
    end
    src[1] = 1'b1;
    do_mret();
    repeat (3) step();
    n_tests++;
    if (pending_o !== '0) begin
      n_fail++;
      $display("FAIL prio_drain: pending_o=%h, expected 00", pending_o);
    end
  endtask

  task automatic test_mie_gate();
    int pulses = 0;
    mie = 1'b0;
    src[3] = 1'b0;
    repeat (EDGE_LAT + 6) begin
      step();
      if (trap_entry_en === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0 || pending_o[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL mie_hold: pulses=%0d pend[3]=%b, expected 0/1", pulses, pending_o[3]);
    end
    exp_q.push_back(IDX_W'(3));
    mie = 1'b1;
    step();
    n_tests++;
    if (trap_entry_en !== 1'b1 || int_index !== IDX_W'(3)) begin
      n_fail++;
      $display("FAIL mie_claim: te=%b idx=%0d, expected 1/3", trap_entry_en, int_index);
    end
    src[3] = 1'b1;
    do_mret();
  endtask

  task automatic test_mask();
    int pulses = 0;
    irq_en[5] = 1'b0;
    src[5] = 1'b1;
    step();
    src[5] = 1'b0;
    repeat (6) begin
      step();
      if (trap_entry_en === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0 || pending_o[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_hold: pulses=%0d pend[5]=%b, expected 0/1", pulses, pending_o[5]);
    end
    exp_q.push_back(IDX_W'(5));
    irq_en[5] = 1'b1;
    step();
    n_tests++;
    if (trap_entry_en !== 1'b1 || int_index !== IDX_W'(5)) begin
      n_fail++;
      $display("FAIL mask_claim: te=%b idx=%0d, expected 1/5", trap_entry_en, int_index);
    end
    repeat (2) step();
    irq_en = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (int_index !== IDX_W'(5) || active_o !== 1'b1) begin
        n_fail++;
        $display("FAIL mask_frozen: idx=%0d act=%b at cycle %0d, expected 5/1", int_index, active_o, k);
      end
    end
    irq_en = 8'hFF;
    do_mret();
  endtask

  task automatic test_level_spacing_reset();
    int gap = 0;
    src[4] = 1'b1;
    mret = 1'b1;
    exp_q.push_back(IDX_W'(4));
    exp_q.push_back(IDX_W'(4));
    wait_trap("lvl_first");
    step();
    gap = 1;
    while (trap_entry_en !== 1'b1 && gap < 10) begin
      step();
      gap++;
    end
    mret = 1'b0;
    n_tests++;
    if (gap != 3 || int_index !== IDX_W'(4)) begin
      n_fail++;
      $display("FAIL lvl_spacing: gap=%0d idx=%0d, expected 3/4", gap, int_index);
    end
    repeat (3) step();
    n_tests++;
    if (active_o !== 1'b1 || pending_o[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL lvl_active: act=%b pend[4]=%b, expected 1/1", active_o, pending_o[4]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pending_o, trap_entry_en, int_index, active_o, trap_exit_en} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: pend=%h te=%b idx=%0d act=%b tx=%b, expected all 0",
               pending_o, trap_entry_en, int_index, active_o, trap_exit_en);
    end
    src[4] = 1'b0;
    step();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) step();
    n_tests++;
    if (pending_o !== '0 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: pend=%h act=%b, expected 00/0", pending_o, active_o);
    end
  endtask

`ifdef INTC_DEBOUNCE_EN
  task automatic test_debounce();
    int seen = -1;
    mie = 1'b0;
    src[0] = 1'b0;
    repeat (10) step();
    src[0] = 1'b1;
    repeat (30) step();
    n_tests++;
    if (pending_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL deb_glitch: pend[0]=%b, expected 0", pending_o[0]);
    end
    src[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (seen < 0 && pending_o[0] === 1'b1) seen = k;
    end
    n_tests++;
    if (seen != int'(EDGE_LAT)) begin
      n_fail++;
      $display("FAIL deb_latency: pending at edge %0d, expected %0d", seen, EDGE_LAT);
    end
    exp_q.push_back(IDX_W'(0));
    mie = 1'b1;
    wait_trap("deb_claim");
    src[0] = 1'b1;
    do_mret();
  endtask
`endif

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_mie_gate();
    test_mask();
`ifdef INTC_DEBOUNCE_EN
    test_debounce();
`endif
    test_level_spacing_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected claims not seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
